keccak_sponge_ctrl: RTL

- Sponge controller and initiator for the Keccak-f[1600] permutation core; it drives that core's istate/ostate handshake from the requesting side.
- Absorbs a byte stream into a rate-sized block, applies SHA-3/SHAKE padding, issues one permutation request per block, then squeezes output bytes.
- Sits between the Kyber hash/XOF users (G, H, PRF, XOF) and the permutation core.

---
 rtl/keccak_sponge_ctrl.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/keccak_sponge_ctrl.sv
// Sponge controller for Keccak-f[1600]: absorbs a byte stream, applies SHA-3/SHAKE
// padding, issues one permutation request per block and squeezes output bytes.
module keccak_sponge_ctrl #(
  parameter int         RATE_BYTES = 168,
  parameter logic [7:0] DOMAIN     = 8'h1F
) (
  input  logic            i_clk,
  input  logic            i_rstn,
  input  logic            i_start,
  input  logic            i_msg_empty,
  input  logic [7:0]      i_in_data,
  input  logic            i_in_valid,
  input  logic            i_in_last,
  output logic            o_in_ready,
  output logic [7:0]      o_out_data,
  output logic            o_out_valid,
  input  logic            i_out_ready,
  output logic            o_busy,
  output logic [1599:0]   o_perm_state,
  output logic            o_perm_valid,
  input  logic            i_perm_ready,
  input  logic [1599:0]   i_perm_state,
  input  logic            i_perm_valid
);
  localparam int         SW   = 1600;
  localparam logic [7:0] LAST = 8'(RATE_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ABSORB, S_PAD, S_PERM_REQ, S_PERM_WAIT, S_SQUEEZE
  } state_e;

  state_e        state_q, state_d;
  logic [SW-1:0] st_q, st_d;
  logic [7:0]    pos_q, pos_d;
  logic          sq_q, sq_d;
  logic          pend_pad_q, pend_pad_d;
  logic          in_ready_q, out_valid_q, perm_valid_q, busy_q;

  logic          do_start, st_clr, st_load, xor_en, pad_tail;
  logic [7:0]    xor_byte, cur_byte;

  // Byte addressed by pos; pos never leaves the rate portion.
  always_comb begin
    cur_byte = '0;
    for (int i = 0; i < RATE_BYTES; i++)
      if (pos_q == 8'(i)) cur_byte = st_q[SW-1-8*i -: 8];
  end

  always_comb begin
    state_d    = state_q;
    pos_d      = pos_q;
    sq_d       = sq_q;
    pend_pad_d = pend_pad_q;
    do_start   = 1'b0;
    st_clr     = 1'b0;
    st_load    = 1'b0;
    xor_en     = 1'b0;
    pad_tail   = 1'b0;
    xor_byte   = '0;
    case (state_q)
      S_IDLE: do_start = i_start;
      S_ABSORB: begin
        if (i_in_valid) begin
          xor_en   = 1'b1;
          xor_byte = i_in_data;
          if (pos_q == LAST) begin
            // A full block closes first; padding goes into the next block.
            pos_d      = '0;
            state_d    = S_PERM_REQ;
            pend_pad_d = i_in_last;
          end else begin
            pos_d = pos_q + 8'd1;
            if (i_in_last) state_d = S_PAD;
          end
        end
      end
      S_PAD: begin
        xor_en   = 1'b1;
        xor_byte = DOMAIN;
        pad_tail = 1'b1;
        sq_d     = 1'b1;
        pos_d    = '0;
        state_d  = S_PERM_REQ;
      end
      S_PERM_REQ: if (i_perm_ready) state_d = S_PERM_WAIT;
      S_PERM_WAIT: begin
        if (i_perm_valid) begin
          st_load = 1'b1;
          pos_d   = '0;
          if (pend_pad_q) begin
            pend_pad_d = 1'b0;
            state_d    = S_PAD;
          end else begin
            state_d = sq_q ? S_SQUEEZE : S_ABSORB;
          end
        end
      end
      S_SQUEEZE: begin
        // A restart discards the byte offered in the same cycle.
        if (i_start) begin
          do_start = 1'b1;
        end else if (i_out_ready) begin
          if (pos_q == LAST) begin
            pos_d   = '0;
            state_d = S_PERM_REQ;
          end else begin
            pos_d = pos_q + 8'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (do_start) begin
      st_clr     = 1'b1;
      pos_d      = '0;
      sq_d       = 1'b0;
      pend_pad_d = 1'b0;
      state_d    = i_msg_empty ? S_PAD : S_ABSORB;
    end
  end

  // Pad byte and 0x80 tail XOR in sequence, so they merge when pos is the last rate byte.
  always_comb begin
    st_d = st_q;
    if (st_clr) begin
      st_d = '0;
    end else if (st_load) begin
      st_d = i_perm_state;
    end else begin
      for (int i = 0; i < RATE_BYTES; i++)
        if (xor_en && pos_q == 8'(i)) st_d[SW-1-8*i -: 8] = st_d[SW-1-8*i -: 8] ^ xor_byte;
      if (pad_tail) st_d[SW-1-8*(RATE_BYTES-1) -: 8] = st_d[SW-1-8*(RATE_BYTES-1) -: 8] ^ 8'h80;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q      <= S_IDLE;
      st_q         <= '0;
      pos_q        <= '0;
      sq_q         <= 1'b0;
      pend_pad_q   <= 1'b0;
      in_ready_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      perm_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      st_q         <= st_d;
      pos_q        <= pos_d;
      sq_q         <= sq_d;
      pend_pad_q   <= pend_pad_d;
      in_ready_q   <= (state_d == S_ABSORB);
      out_valid_q  <= (state_d == S_SQUEEZE);
      perm_valid_q <= (state_d == S_PERM_REQ);
      busy_q       <= (state_d != S_IDLE);
    end
  end

  assign o_in_ready   = in_ready_q;
  assign o_out_valid  = out_valid_q;
  assign o_out_data   = out_valid_q ? cur_byte : 8'h00;
  assign o_perm_valid = perm_valid_q;
  assign o_perm_state = st_q;
  assign o_busy       = busy_q;
endmodule
